// File: rtl/branch_ex_pkg.sv
// Shared widths and opcode encodings for the branch execution unit and its comparator.
package branch_ex_pkg;

    localparam int unsigned OpWidth   = 6;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned TagWidth  = 4;

    localparam logic [OpWidth-1:0] OpJal  = 6'd1;
    localparam logic [OpWidth-1:0] OpJalr = 6'd2;
    localparam logic [OpWidth-1:0] OpBeq  = 6'd3;
    localparam logic [OpWidth-1:0] OpBne  = 6'd4;
    localparam logic [OpWidth-1:0] OpBlt  = 6'd5;
    localparam logic [OpWidth-1:0] OpBge  = 6'd6;
    localparam logic [OpWidth-1:0] OpBltu = 6'd7;
    localparam logic [OpWidth-1:0] OpBgeu = 6'd8;

    localparam logic Valid   = 1'b1;
    localparam logic Invalid = 1'b0;

    function automatic logic is_jump(input logic [OpWidth-1:0] op);
        return (op == OpJal) || (op == OpJalr);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition resolver: taken flag plus a legal-opcode flag.
module branch_cmp
    import branch_ex_pkg::*;
(
    input  logic [OpWidth-1:0]   op,
    input  logic [DataWidth-1:0] reg1,
    input  logic [DataWidth-1:0] reg2,
    output logic                 taken,
    output logic                 legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (op)
            OpJal, OpJalr: taken = 1'b1;
            OpBeq:  taken = (reg1 == reg2);
            OpBne:  taken = (reg1 != reg2);
            OpBlt:  taken = ($signed(reg1) <  $signed(reg2));
            OpBge:  taken = ($signed(reg1) >= $signed(reg2));
            OpBltu: taken = (reg1 <  reg2);
            OpBgeu: taken = (reg1 >= reg2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ex.sv
// Branch execution unit: resolves condition, target and link value, and drives the
// Branch CDB through a single register stage (latency 1, one beat per issue).
module branch_ex
    import branch_ex_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clear,
    input  logic                 Branch_valid,
    input  logic [OpWidth-1:0]   Branch_op,
    input  logic [DataWidth-1:0] Branch_reg1,
    input  logic [DataWidth-1:0] Branch_reg2,
    input  logic [DataWidth-1:0] Branch_imm,
    input  logic [AddrWidth-1:0] Branch_pc,
    input  logic [TagWidth-1:0]  Branch_reg_des_rob,
    output logic                 Branch_cdb_valid,
    output logic [TagWidth-1:0]  Branch_cdb_tag,
    output logic [DataWidth-1:0] Branch_cdb_data,
    output logic                 Branch_cdb_jump,
    output logic [AddrWidth-1:0] Branch_cdb_target
);

    logic                 taken;
    logic                 legal;
    logic [AddrWidth-1:0] pc_plus4;
    logic [AddrWidth-1:0] pc_plus_imm;
    logic [AddrWidth-1:0] jalr_target;

    logic                 valid_d, valid_q;
    logic [TagWidth-1:0]  tag_d, tag_q;
    logic [DataWidth-1:0] data_d, data_q;
    logic                 jump_d, jump_q;
    logic [AddrWidth-1:0] target_d, target_q;

    branch_cmp u_cmp (
        .op    (Branch_op),
        .reg1  (Branch_reg1),
        .reg2  (Branch_reg2),
        .taken (taken),
        .legal (legal)
    );

    assign pc_plus4    = Branch_pc + 32'd4;
    assign pc_plus_imm = Branch_pc + Branch_imm;
    assign jalr_target = (Branch_reg1 + Branch_imm) & ~32'd1;

    // Idle cycles load an all-zero beat so the bus is clean when nothing is issued.
    always_comb begin
        valid_d  = Invalid;
        tag_d    = '0;
        data_d   = '0;
        jump_d   = 1'b0;
        target_d = '0;
        if (Branch_valid) begin
            valid_d  = Valid;
            tag_d    = Branch_reg_des_rob;
            jump_d   = legal && taken;
            target_d = pc_plus4;
            if (legal && taken) begin
                target_d = (Branch_op == OpJalr) ? jalr_target : pc_plus_imm;
            end
            if (is_jump(Branch_op)) begin
                data_d = pc_plus4;
            end
        end
    end

    // rst/clear win over a coincident issue; rdy=0 freezes the whole stage.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q  <= Invalid;
            tag_q    <= '0;
            data_q   <= '0;
            jump_q   <= 1'b0;
            target_q <= '0;
        end else if (rdy) begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end
    end

    assign Branch_cdb_valid  = valid_q;
    assign Branch_cdb_tag    = tag_q;
    assign Branch_cdb_data   = data_q;
    assign Branch_cdb_jump   = jump_q;
    assign Branch_cdb_target = target_q;

endmodule

// File: doc/branch_ex.md
# branch_ex

Branch execution unit, the consumer of the branch reservation station's issue port. Each cycle it accepts at most one ready branch or jump: opcode, both operands, immediate, PC and destination ROB tag. It resolves the condition, computes the target and the link value, and broadcasts the result one cycle later on the Branch CDB. That CDB feeds the RSs, the LSB and the ROB, and the ROB uses the jump flag and target to redirect fetch on commit.

## Interface
Parameters:
- none; all widths come from `cpu_define.v` (`OPBus`, `DataBus`, `AddressBus`, `TagBus`).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = hold all state and outputs
- clear  in  1  mispredict flush from ROB; synchronous, same effect as rst
- Branch_valid  in  1  issue strobe from RS
- Branch_op  in  `OPBus`  operation: JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU
- Branch_reg1  in  `DataBus`  rs1 value
- Branch_reg2  in  `DataBus`  rs2 value
- Branch_imm  in  `DataBus`  sign-extended immediate
- Branch_pc  in  `AddressBus`  instruction PC
- Branch_reg_des_rob  in  `TagBus`  destination ROB tag
- Branch_cdb_valid  out  1  result strobe
- Branch_cdb_tag  out  `TagBus`  ROB tag of result
- Branch_cdb_data  out  `DataBus`  link value (rd write data)
- Branch_cdb_jump  out  1  1 = taken, 0 = fall-through
- Branch_cdb_target  out  `AddressBus`  resolved next PC

## Operation
- No backpressure; the RS issues at most one entry per cycle, and every accepted issue produces exactly one CDB beat.
- Capture condition: rdy && !rst && !clear && Branch_valid.
- Condition evaluation:
  - BEQ: reg1==reg2; BNE: !=.
  - BLT and BGE: signed compare.
  - BLTU and BGEU: unsigned compare.
  - JAL and JALR: always taken.
- Target:
  - Taken conditional branch and JAL: pc+imm.
  - JALR: (reg1+imm) & ~1.
  - Not taken: pc+4.
  - All sums mod 2^32; no overflow detection.
- Data: pc+4 for JAL and JALR; 0 for conditional branches (the ROB ignores rd for these).
- Unrecognised op: still produces a beat with tag passed through, jump=0, target=pc+4, data=0; it must never hang the ROB entry.
- Cycle with no capture and rdy=1: cdb_valid=0, tag/data/jump/target = 0.

## Timing
- Latency 1: issue sampled at edge N, result visible after edge N and valid for exactly one cycle. Throughput is one result per cycle.
- Back-to-back issues produce back-to-back CDB beats with no bubble.
- Reset values, after a rst or clear edge: all outputs 0, Branch_cdb_valid=0.
- rst/clear priority:
  - They win over a simultaneous Branch_valid; the issued instruction is discarded, since the RS is also flushing.
  - A beat launched in the cycle before clear stays visible for its one cycle; consumers mask it with clear themselves.
- rdy=0:
  - The output register holds its value, including a held cdb_valid=1; the same beat is re-presented when rdy returns.
  - Branch_valid is ignored while rdy=0.
  - The RS is also frozen, so this is not a duplicate issue.

## Structure
- `cpu_define.v`: op constants for the eight ops, bus widths, `Valid`/`Invalid`/`Null`.
- Sub-module `branch_cmp`: purely combinational. Inputs op, reg1, reg2; output taken, plus an op-legal flag.
- `branch_ex` holds the adders, the target mux and the single output register stage.

## Test plan
- BEQ, reg1=5, reg2=5, pc=0x100, imm=0x20, tag=3 -> next cycle valid=1, tag=3, jump=1, target=0x120, data=0. Repeat with reg2=6 -> jump=0, target=0x104.
- BLT vs BLTU with reg1=0xFFFFFFFF, reg2=1 -> BLT jump=1; BLTU jump=0, target=pc+4.
- JALR, reg1=0x1003, imm=0x4, pc=0x200 -> target=0x1006 (bit0 cleared), data=0x204, jump=1. JAL pc=0x10, imm=-8 -> target=0x8.
- Four consecutive issues with tags 1,2,3,4 -> four consecutive beats in order with tags 1..4, no gaps. Then one idle cycle -> valid=0 and all fields 0.
- Issue then rdy=0 for 3 cycles -> beat held unchanged for 3 cycles. Issue during rdy=0 -> no extra beat.
- clear asserted coincident with Branch_valid -> next cycle all outputs 0. Reset mid-stream -> same result. Unknown op -> beat with jump=0, target=pc+4.
